// File: rtl/bp_io_cmd_arbiter.sv
// bp_io_cmd_arbiter
// Round-robin arbiter that merges several BedRock I/O command requesters onto
// one shared command port. Commands are credit limited. Responses come back in
// order and are steered to the requester that issued them, using an in-order
// tag FIFO.
module bp_io_cmd_arbiter #(
    parameter int num_req_p     = 2,
    parameter int hdr_width_p   = 128,
    parameter int data_width_p  = 512,
    parameter int max_credits_p = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic [num_req_p*hdr_width_p-1:0]  req_header_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_yumi_o,

    output logic [hdr_width_p-1:0]            io_cmd_header_o,
    output logic [data_width_p-1:0]           io_cmd_data_o,
    output logic                              io_cmd_v_o,
    input  logic                              io_cmd_yumi_i,

    input  logic [hdr_width_p-1:0]            io_resp_header_i,
    input  logic [data_width_p-1:0]           io_resp_data_i,
    input  logic                              io_resp_v_i,
    output logic                              io_resp_ready_o,

    output logic [hdr_width_p-1:0]            resp_header_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic [num_req_p-1:0]              resp_v_o,
    input  logic [num_req_p-1:0]              resp_ready_i,

    output logic                              idle_o,
    output logic                              error_o
);

    // Requester count is limited to 2..4, so a tag is one or two bits wide.
    localparam int tag_w_lp  = (num_req_p > 2) ? 2 : 1;
    localparam int ptr_w_lp  = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;
    localparam int cred_w_lp = $clog2(max_credits_p + 1);

    logic [tag_w_lp-1:0]  ptr_r;
    logic                 lock_r;
    logic [tag_w_lp-1:0]  lock_idx_r;
    logic [cred_w_lp-1:0] credits_r;
    logic [ptr_w_lp-1:0]  rd_ptr_r;
    logic [ptr_w_lp-1:0]  wr_ptr_r;
    logic                 error_r;
    logic                 active_r;
    logic [tag_w_lp-1:0]  tag_mem [max_credits_p];

    logic [tag_w_lp-1:0]  rr_idx;
    logic                 rr_v;
    logic [tag_w_lp:0]    rr_sum;
    logic [tag_w_lp-1:0]  grant_idx;
    logic                 grant_v;
    logic                 credit_ok;
    logic                 cmd_fire;
    logic                 fifo_nonempty;
    logic [tag_w_lp-1:0]  head_tag;
    logic                 resp_fire;

    // Round-robin search: walk the offsets from highest to lowest so that the
    // requester closest to ptr_r is the one left selected.
    always_comb begin
        rr_idx = ptr_r;
        rr_v   = 1'b0;
        rr_sum = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            rr_sum = {1'b0, ptr_r} + (tag_w_lp + 1)'(i);
            if (rr_sum >= (tag_w_lp + 1)'(num_req_p)) begin
                rr_sum = rr_sum - (tag_w_lp + 1)'(num_req_p);
            end
            if (req_v_i[rr_sum[tag_w_lp-1:0]]) begin
                rr_idx = rr_sum[tag_w_lp-1:0];
                rr_v   = 1'b1;
            end
        end
    end

    // A command offered but not yet taken keeps its grant. Without this the
    // command port would change under a stalled downstream.
    assign grant_idx = lock_r ? lock_idx_r : rr_idx;
    assign grant_v   = lock_r ? req_v_i[lock_idx_r] : rr_v;
    assign credit_ok = (credits_r < cred_w_lp'(max_credits_p));

    // active_r keeps the port quiet while reset is held and during the cycle
    // in which reset is released.
    assign io_cmd_v_o      = active_r & grant_v & credit_ok;
    assign cmd_fire        = io_cmd_v_o & io_cmd_yumi_i;
    assign io_cmd_header_o = req_header_i[grant_idx*hdr_width_p +: hdr_width_p];
    assign io_cmd_data_o   = req_data_i[grant_idx*data_width_p +: data_width_p];

    // The credit count equals the tag FIFO occupancy. A response that arrives
    // with the FIFO empty is accepted and dropped, so the port cannot stall.
    assign fifo_nonempty   = (credits_r != '0);
    assign head_tag        = tag_mem[rd_ptr_r];
    assign io_resp_ready_o = fifo_nonempty ? resp_ready_i[head_tag] : 1'b1;
    assign resp_fire       = io_resp_v_i & io_resp_ready_o & fifo_nonempty;
    assign resp_header_o   = io_resp_header_i;
    assign resp_data_o     = io_resp_data_i;

    generate
        for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
            assign req_yumi_o[gi] = cmd_fire & (grant_idx == tag_w_lp'(gi));
            assign resp_v_o[gi]   = io_resp_v_i & fifo_nonempty & (head_tag == tag_w_lp'(gi));
        end
    endgenerate

    assign idle_o  = (credits_r == '0) & ~|req_v_i;
    assign error_o = error_r;

    // Tag storage. Contents are only meaningful between rd_ptr_r and wr_ptr_r,
    // so this array has no reset.
    always_ff @(posedge clk_i) begin
        if (cmd_fire) begin
            tag_mem[wr_ptr_r] <= grant_idx;
        end
    end

    // Control state: priority pointer, grant lock, FIFO pointers, credits and
    // the sticky error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            active_r   <= 1'b0;
            ptr_r      <= '0;
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
            credits_r  <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            error_r    <= 1'b0;
        end else begin
            active_r   <= 1'b1;
            lock_r     <= io_cmd_v_o & ~io_cmd_yumi_i;
            lock_idx_r <= grant_idx;
            if (cmd_fire) begin
                ptr_r    <= (grant_idx == tag_w_lp'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_credits_p - 1)) ? '0 : wr_ptr_r + 1'b1;
            end
            if (resp_fire) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_credits_p - 1)) ? '0 : rd_ptr_r + 1'b1;
            end
            if (cmd_fire && !resp_fire) begin
                credits_r <= credits_r + 1'b1;
            end else if (!cmd_fire && resp_fire) begin
                credits_r <= credits_r - 1'b1;
            end
            if (io_resp_v_i && !fifo_nonempty) begin
                error_r <= 1'b1;
            end
        end
    end

endmodule
